// File: rtl/acc_pkg.sv
// acc_pkg: shared encodings and ICB constants for the accelerator datapath engines.
package acc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    localparam int         ICB_WORD_BYTES = 4;
    localparam logic [3:0] ICB_FULL_WMASK = 4'hF;
endpackage

// File: rtl/icb_burst_master.sv
// icb_burst_master: sequential 32-bit ICB initiator with a read stream out and a write stream in.
// Define ICB_MASTER_ERR_ABORT_EN to stop issuing on an error response and expose err_flag.
module icb_burst_master
    import acc_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int MAX_OST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_read,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             done,
`ifdef ICB_MASTER_ERR_ABORT_EN
    output logic             err_flag,
`endif
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_addr,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);
    state_e           state_q, state_d;
    logic [31:0]      base_q;
    logic [LEN_W-1:0] len_q, issued_q, issued_d;
    logic [3:0]       ost_q, ost_d;
    logic             dir_read_q, abort_q, live_q, req_ready_q, done_q;
    logic             cmd_valid_q, cmd_valid_d, cmd_read_q;
    logic [31:0]      cmd_addr_q, cmd_wdata_q;
    logic [3:0]       cmd_wmask_q;
    logic             busy, req_fire, cmd_fire, rsp_fire, err_hit, stop, room, load;

    assign busy     = state_q != IDLE;
    assign req_fire = req_valid & req_ready_q;
    assign cmd_fire = cmd_valid_q & icb_cmd_ready;
    assign rsp_fire = icb_rsp_valid & icb_rsp_ready;
    assign stop     = abort_q | err_hit;
    // The word parked in the cmd register will become outstanding, so it counts against the limit.
    assign room     = ({1'b0, ost_q} + 5'(cmd_valid_q)) < 5'(MAX_OST);
    assign load     = (state_q == RUN) & (issued_q != len_q) & (~cmd_valid_q | icb_cmd_ready) &
                      room & (dir_read_q | wr_valid) & ~stop;

    assign ost_d       = ost_q + 4'(cmd_fire) - 4'(rsp_fire & busy);
    assign issued_d    = req_fire ? '0 : issued_q + LEN_W'(load);
    assign cmd_valid_d = load | (cmd_valid_q & ~icb_cmd_ready);

    always_comb begin
        state_d = state_q == IDLE  ? (req_fire ? (req_len == '0 ? DONE : RUN) : IDLE) :
                  state_q == RUN   ? ((issued_d == len_q || stop) ? DRAIN : RUN) :
                  state_q == DRAIN ? ((ost_d == '0 && !cmd_valid_d) ? DONE : DRAIN) :
                                     IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            ost_q       <= '0;
            dir_read_q  <= 1'b0;
            abort_q     <= 1'b0;
            live_q      <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            req_ready_q <= state_d == IDLE;
            done_q      <= state_d == DONE;
            issued_q    <= issued_d;
            ost_q       <= ost_d;
            cmd_valid_q <= cmd_valid_d;
            abort_q     <= req_fire ? 1'b0 : (abort_q | err_hit);
            if (req_fire) begin
                base_q     <= req_addr;
                len_q      <= req_len;
                dir_read_q <= req_read;
            end
            if (load) begin
                cmd_read_q  <= dir_read_q;
                cmd_addr_q  <= base_q + 32'(issued_q) * 32'(ICB_WORD_BYTES);
                cmd_wdata_q <= dir_read_q ? '0 : wr_data;
                cmd_wmask_q <= ICB_FULL_WMASK;
            end
        end
    end

`ifdef ICB_MASTER_ERR_ABORT_EN
    logic err_flag_q;
    assign err_hit  = rsp_fire & busy & icb_rsp_err;
    assign err_flag = err_flag_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_flag_q <= 1'b0;
        else        err_flag_q <= req_fire ? 1'b0 : (err_flag_q | err_hit);
    end
`else
    logic unused_err;
    assign unused_err = icb_rsp_err;
    assign err_hit    = 1'b0;
`endif

    assign req_ready     = req_ready_q;
    assign done          = done_q;
    assign wr_ready      = load & ~dir_read_q;
    assign icb_cmd_valid = cmd_valid_q;
    assign icb_cmd_read  = cmd_read_q;
    assign icb_cmd_addr  = cmd_addr_q;
    assign icb_cmd_wdata = cmd_wdata_q;
    assign icb_cmd_wmask = cmd_wmask_q;
    // Stray responses outside a burst are swallowed; reads otherwise follow the consumer.
    assign icb_rsp_ready = live_q & (~busy | ~dir_read_q | rd_ready);
    assign rd_valid      = dir_read_q & busy & icb_rsp_valid;
    assign rd_data       = rd_valid ? icb_rsp_rdata : '0;
endmodule
